game_status_ctrl: RTL and testbench
===================================

// Module: game_status_ctrl
// PURPOSE
//  Game-progress controller directly upstream of the text overlay stage.
//  Counts player deaths (with per-player invulnerability windows), advances the level on wave clear,
//  and decides game over. Drives the overlay's level, dead_count_1 and dead_count_2 inputs from registers.
//  Frame timing comes from the VGA vsync: one frame tick per vsync rising edge.
// PARAMETERS
//  MAX_LIVES      3   deaths per player before that player is out (dead count saturates here)
//  MAX_LEVEL      9   highest level value; level saturates here
//  INVULN_FRAMES  60  frames a player ignores hits after a counted hit (1..255)
//  LVLUP_FRAMES   120 frames of LEVEL_UP pause before play resumes (1..255)
// PORTS
//  pclk           in   1  pixel clock; all logic on rising edge
//  rst            in   1  asynchronous, active-low reset
//  vsync_in       in   1  VGA vsync from the timing chain
//  start          in   1  start/restart request, level-sensitive, sampled each pclk
//  p1_hit         in   1  player 1 hit, 1-pclk pulse
//  p2_hit         in   1  player 2 hit, 1-pclk pulse
//  wave_cleared   in   1  all enemies destroyed, 1-pclk pulse
//  level          out  4  current level, 1..MAX_LEVEL
//  dead_count_1   out  4  player 1 deaths, 0..MAX_LIVES
//  dead_count_2   out  4  player 2 deaths, 0..MAX_LIVES
//  play_en        out  1  1 only in PLAY; gameplay logic freezes when 0
//  game_over      out  1  1 only in GAME_OVER
// BEHAVIOUR
//  Reset (rst=0, async)
//   - state IDLE; level=1; dead counts=0; play_en=0; game_over=0.
//   - Both invuln counters and lvl_cnt cleared; vsync edge register cleared.
//  Frame tick
//   - vsync_d <= vsync_in.
//   - frame_tick = vsync_in & ~vsync_d, combinational, 1 pclk wide.
//  Outputs: all registered; each changes 1 pclk after the causing input edge.
//  FSM
//   IDLE     : start=1 -> PLAY; clear dead counts; level=1; clear invuln counters.
//   PLAY     : Hits
//               - pN_hit with invulnN==0 and dead_count_N<MAX_LIVES
//                 -> dead_count_N+1 and invulnN=INVULN_FRAMES.
//               - Otherwise the hit is ignored.
//               - p1_hit and p2_hit in the same cycle are handled independently.
//              Counters: invulnN decrements on frame_tick while nonzero.
//              Game over: if both dead counts == MAX_LIVES after the update -> GAME_OVER, next cycle.
//              Wave clear: wave_cleared=1 (and not going to GAME_OVER)
//               - level saturating +1.
//               - lvl_cnt=LVLUP_FRAMES.
//               - -> LEVEL_UP.
//              Priority: same-cycle hit and wave_cleared -> hit counted first.
//               - If that hit ends the game, GAME_OVER wins and level is unchanged.
//   LEVEL_UP : play_en=0; hits and wave_cleared ignored.
//              lvl_cnt decrements on frame_tick; when it reaches 0 -> PLAY.
//   GAME_OVER: game_over=1; counts and level held.
//              Leave on a start rising edge (start & ~start_d) -> IDLE.
//              start held high from before entry never re-triggers.
//  Saturation and timing rules
//   - A player at MAX_LIVES is out: further hits are ignored and the count never wraps.
//   - Level never exceeds MAX_LEVEL; at MAX_LEVEL a clear still enters LEVEL_UP.
//   - frame_tick in the same cycle as a counted hit: invuln loads INVULN_FRAMES and does not decrement.
//   - Invulnerability therefore lasts INVULN_FRAMES full vsync edges.
//  Reset mid-game: any state -> IDLE immediately, all counts cleared asynchronously.
// TESTING
//  1) Reset, start=1 for 1 cycle
//     -> PLAY, play_en=1 next cycle, level=1, dead counts 0.
//  2) p1_hit, then 2nd p1_hit 10 frames later (INVULN_FRAMES=60)
//     -> dead_count_1=1 after the first; the second is ignored.
//     -> A p1_hit after 60 vsync edges gives dead_count_1=2.
//  3) p1_hit and p2_hit in the same cycle
//     -> dead_count_1 and dead_count_2 both increment by 1.
//  4) Drive both players to MAX_LIVES=3
//     -> game_over=1, play_en=0 one cycle after the final hit; extra hits keep counts at 3.
//  5) wave_cleared at level 9 (MAX_LEVEL=9)
//     -> level stays 9, LEVEL_UP for 120 vsync edges with play_en=0, then PLAY.
//  6) rst low during LEVEL_UP, then start held high through GAME_OVER entry
//     -> outputs at reset values immediately; no exit from GAME_OVER until start falls and rises.

Source files
------------

// File: rtl/game_status_ctrl.sv
// game_status_ctrl: game-progress controller feeding the text overlay.
// Counts per-player deaths with invulnerability windows, advances the level
// on wave clear, pauses for a level-up interval and decides game over.
// Frame timing is one tick per rising edge of the VGA vsync.
module game_status_ctrl #(
    parameter int unsigned MAX_LIVES     = 3,
    parameter int unsigned MAX_LEVEL     = 9,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned LVLUP_FRAMES  = 120
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       start,
    input  logic       p1_hit,
    input  logic       p2_hit,
    input  logic       wave_cleared,
    output logic [3:0] level,
    output logic [3:0] dead_count_1,
    output logic [3:0] dead_count_2,
    output logic       play_en,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_LEVEL_UP,
        S_GAME_OVER
    } state_t;

    localparam logic [3:0] LIVES_MAX   = 4'(MAX_LIVES);
    localparam logic [3:0] LEVEL_MAX   = 4'(MAX_LEVEL);
    localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);
    localparam logic [7:0] LVLUP_LOAD  = 8'(LVLUP_FRAMES);

    state_t     state, state_nx;
    logic       vsync_d, start_d;
    logic       frame_tick, start_rise;
    logic [7:0] invuln_1, invuln_1_nx;
    logic [7:0] invuln_2, invuln_2_nx;
    logic [7:0] lvl_cnt, lvl_cnt_nx;
    logic [3:0] level_nx, dead_1_nx, dead_2_nx;
    logic       play_en_nx, game_over_nx;
    logic       hit_1_ok, hit_2_ok;

    assign frame_tick = vsync_in & ~vsync_d;
    assign start_rise = start & ~start_d;
    assign hit_1_ok   = p1_hit && (invuln_1 == '0) && (dead_count_1 < LIVES_MAX);
    assign hit_2_ok   = p2_hit && (invuln_2 == '0) && (dead_count_2 < LIVES_MAX);

    // State, counters, edge detectors and registered outputs
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            vsync_d      <= 1'b0;
            start_d      <= 1'b0;
            invuln_1     <= '0;
            invuln_2     <= '0;
            lvl_cnt      <= '0;
            level        <= 4'd1;
            dead_count_1 <= '0;
            dead_count_2 <= '0;
            play_en      <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_nx;
            vsync_d      <= vsync_in;
            start_d      <= start;
            invuln_1     <= invuln_1_nx;
            invuln_2     <= invuln_2_nx;
            lvl_cnt      <= lvl_cnt_nx;
            level        <= level_nx;
            dead_count_1 <= dead_1_nx;
            dead_count_2 <= dead_2_nx;
            play_en      <= play_en_nx;
            game_over    <= game_over_nx;
        end
    end

    // Next-state, counter updates; outputs are decoded from the next state
    // so they appear one pclk after the causing input
    always_comb begin
        state_nx    = state;
        invuln_1_nx = invuln_1;
        invuln_2_nx = invuln_2;
        lvl_cnt_nx  = lvl_cnt;
        level_nx    = level;
        dead_1_nx   = dead_count_1;
        dead_2_nx   = dead_count_2;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx    = S_PLAY;
                    dead_1_nx   = '0;
                    dead_2_nx   = '0;
                    level_nx    = 4'd1;
                    invuln_1_nx = '0;
                    invuln_2_nx = '0;
                end
            end
            S_PLAY: begin
                // A counted hit reloads the window and overrides a same-cycle tick
                if (hit_1_ok) begin
                    dead_1_nx   = dead_count_1 + 4'd1;
                    invuln_1_nx = INVULN_LOAD;
                end else if (frame_tick && invuln_1 != '0) begin
                    invuln_1_nx = invuln_1 - 8'd1;
                end
                if (hit_2_ok) begin
                    dead_2_nx   = dead_count_2 + 4'd1;
                    invuln_2_nx = INVULN_LOAD;
                end else if (frame_tick && invuln_2 != '0) begin
                    invuln_2_nx = invuln_2 - 8'd1;
                end
                if (dead_1_nx == LIVES_MAX && dead_2_nx == LIVES_MAX) begin
                    state_nx = S_GAME_OVER;
                end else if (wave_cleared) begin
                    if (level < LEVEL_MAX) begin
                        level_nx = level + 4'd1;
                    end
                    lvl_cnt_nx = LVLUP_LOAD;
                    state_nx   = S_LEVEL_UP;
                end
            end
            S_LEVEL_UP: begin
                if (lvl_cnt == '0) begin
                    state_nx = S_PLAY;
                end else if (frame_tick) begin
                    lvl_cnt_nx = lvl_cnt - 8'd1;
                    if (lvl_cnt == 8'd1) begin
                        state_nx = S_PLAY;
                    end
                end
            end
            S_GAME_OVER: begin
                if (start_rise) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        play_en_nx   = (state_nx == S_PLAY);
        game_over_nx = (state_nx == S_GAME_OVER);
    end

endmodule

// File: tb/tb_game_status_ctrl.sv
// Scoreboard bench for game_status_ctrl: expected outputs are queued as
// stimulus is applied and compared once the DUT has registered its response.
module tb_game_status_ctrl;

    logic       pclk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync_in = 1'b0;
    logic       start = 1'b0;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic       wave_cleared = 1'b0;
    logic [3:0] level, dead_count_1, dead_count_2;
    logic       play_en, game_over;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [3:0] lvl;
        logic [3:0] d1;
        logic [3:0] d2;
        logic       pe;
        logic       go;
    } exp_t;

    exp_t sb[$];

    game_status_ctrl #(
        .MAX_LIVES    (3),
        .MAX_LEVEL    (9),
        .INVULN_FRAMES(60),
        .LVLUP_FRAMES (120)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .start       (start),
        .p1_hit      (p1_hit),
        .p2_hit      (p2_hit),
        .wave_cleared(wave_cleared),
        .level       (level),
        .dead_count_1(dead_count_1),
        .dead_count_2(dead_count_2),
        .play_en     (play_en),
        .game_over   (game_over)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] lvl, input logic [3:0] d1,
                            input logic [3:0] d2, input logic pe, input logic go);
        exp_t e;
        e.tag = tag; e.lvl = lvl; e.d1 = d1; e.d2 = d2; e.pe = pe; e.go = go;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".level"},     32'(level),        32'(e.lvl));
        check({e.tag, ".dead1"},     32'(dead_count_1), 32'(e.d1));
        check({e.tag, ".dead2"},     32'(dead_count_2), 32'(e.d2));
        check({e.tag, ".play_en"},   32'(play_en),      32'(e.pe));
        check({e.tag, ".game_over"}, 32'(game_over),    32'(e.go));
    endtask

    // inputs change 1ns after the rising edge, outputs sampled there too
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic frames(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            vsync_in = 1'b1; cyc();
            vsync_in = 1'b0; cyc();
            cyc();
        end
    endtask

    // one-cycle pulse of hits/clear, then compare against queued expectation
    task automatic pulse(input logic h1, input logic h2, input logic wc);
        p1_hit = h1; p2_hit = h2; wave_cleared = wc;
        cyc();
        p1_hit = 1'b0; p2_hit = 1'b0; wave_cleared = 1'b0;
        pop_check();
    endtask

    initial begin
        // 1) reset and start
        push_exp("reset", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc(); cyc();
        pop_check();
        rst = 1'b1;
        cyc();
        start = 1'b1;
        push_exp("start", 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
        cyc();
        start = 1'b0;
        pop_check();

        // 2) invulnerability window
        push_exp("p1_first_hit", 4'd1, 4'd1, 4'd0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        frames(10);
        push_exp("p1_hit_10f", 4'd1, 4'd1, 4'd0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        frames(49);
        push_exp("p1_hit_59f", 4'd1, 4'd1, 4'd0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        frames(1);
        push_exp("p1_hit_60f", 4'd1, 4'd2, 4'd0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);

        // 3) simultaneous hits
        frames(60);
        push_exp("both_hit", 4'd1, 4'd3, 4'd1, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);

        // 4) player 1 is out; bring player 2 to the limit
        frames(60);
        push_exp("p2_hit2", 4'd1, 4'd3, 4'd2, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        frames(60);
        push_exp("final_hit", 4'd1, 4'd3, 4'd3, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        frames(61);
        push_exp("hits_after_over", 4'd1, 4'd3, 4'd3, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 1'b0);

        // leave GAME_OVER on a start rising edge, then IDLE starts a new game
        start = 1'b1;
        push_exp("over_to_idle", 4'd1, 4'd3, 4'd3, 1'b0, 1'b0);
        cyc();
        pop_check();
        push_exp("idle_to_play", 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
        cyc();
        start = 1'b0;
        pop_check();

        // 5) level-up sequence up to and past MAX_LEVEL
        for (int unsigned k = 2; k <= 10; k++) begin
            logic [3:0] lv;
            lv = (k > 9) ? 4'd9 : 4'(k);
            push_exp($sformatf("clear_L%0d", k), lv, 4'd0, 4'd0, 1'b0, 1'b0);
            pulse(1'b0, 1'b0, 1'b1);
            if (k == 2) begin
                frames(5);
                push_exp("lvlup_ignores_input", lv, 4'd0, 4'd0, 1'b0, 1'b0);
                pulse(1'b1, 1'b1, 1'b1);
                frames(114);
            end else begin
                frames(119);
            end
            push_exp($sformatf("lvlup_119f_L%0d", k), lv, 4'd0, 4'd0, 1'b0, 1'b0);
            cyc();
            pop_check();
            frames(1);
            push_exp($sformatf("lvlup_done_L%0d", k), lv, 4'd0, 4'd0, 1'b1, 1'b0);
            cyc();
            pop_check();
        end

        // hit and clear together: hit counted, level saturated, LEVEL_UP entered
        push_exp("hit_and_clear", 4'd9, 4'd1, 4'd0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);

        // 6) asynchronous reset in LEVEL_UP
        frames(3);
        push_exp("async_reset", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        pop_check();
        cyc();
        rst = 1'b1;
        start = 1'b1;
        push_exp("restart_held", 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
        cyc();
        pop_check();
        push_exp("go_hit1", 4'd1, 4'd1, 4'd1, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        frames(60);
        push_exp("go_hit2", 4'd1, 4'd2, 4'd2, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        frames(60);
        push_exp("go_wins_over_clear", 4'd1, 4'd3, 4'd3, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 1'b1);
        cyc(); cyc(); cyc();
        push_exp("start_held_no_exit", 4'd1, 4'd3, 4'd3, 1'b0, 1'b1);
        cyc();
        pop_check();
        start = 1'b0;
        push_exp("start_low_stays", 4'd1, 4'd3, 4'd3, 1'b0, 1'b1);
        cyc();
        pop_check();
        start = 1'b1;
        push_exp("start_rise_exit", 4'd1, 4'd3, 4'd3, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        pop_check();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
